// File: rtl/sdram_cmd_responder.sv
// SDRAM device emulator: decodes the zs_* command bus and serves reads/writes from on-chip RAM.
// Define SDRAM_DQM_EN to honour zs_dqm byte masks on write beats and read output.
module sdram_cmd_responder #(
    parameter int ROW_KEEP = 2,
    parameter int COL_KEEP = 6,
    parameter int MEM_AW   = 2 + ROW_KEEP + COL_KEEP
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        zs_cke,
    input  logic        zs_cs_n,
    input  logic        zs_ras_n,
    input  logic        zs_cas_n,
    input  logic        zs_we_n,
    input  logic [1:0]  zs_ba,
    input  logic [11:0] zs_addr,
    input  logic [1:0]  zs_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [2:0]  err
);
    // Handshake: none; every command is accepted on the clk edge where zs_cke is high.
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
    state_t state, state_nxt;

    logic [15:0]         mem [0:(1<<MEM_AW)-1];
    logic [3:0]          bank_open;
    logic [ROW_KEEP-1:0] open_row [4];
    logic [1:0]          cl;
    logic [2:0]          bl_mask;
    logic                mode_set;

    logic [1:0]          b_ba;
    logic [ROW_KEEP-1:0] b_row;
    logic [7:0]          b_col;
    logic [2:0]          b_mask, b_left;
    logic                b_ap;

    logic [2:0]          p_vld;
    logic [MEM_AW-1:0]   p_idx [3];
    logic [1:0]          p_dqm [3];

    logic [3:0]          cmd;
    logic                is_act, is_rd, is_wr, is_pre, is_lmr;
    logic                new_rd, new_wr, iss_rd, iss_wr, iss_ap;
    logic [1:0]          iss_ba, tap;
    logic [ROW_KEEP-1:0] iss_row;
    logic [7:0]          iss_col, col_nxt;
    logic [2:0]          iss_mask, iss_rem;
    logic [MEM_AW-1:0]   iss_idx;
    logic [15:0]         rd_word;
    logic                rd_oe;
    logic                unused_in;

    assign cmd    = {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n};
    assign is_act = zs_cke && (cmd == 4'b0011);
    assign is_rd  = zs_cke && (cmd == 4'b0101);
    assign is_wr  = zs_cke && (cmd == 4'b0100);
    assign is_pre = zs_cke && (cmd == 4'b0010);
    assign is_lmr = zs_cke && (cmd == 4'b0000);
    assign new_rd = is_rd && mode_set && bank_open[zs_ba];
    assign new_wr = is_wr && mode_set && bank_open[zs_ba];
    assign unused_in = ^{zs_addr[11:8], zs_dqm};

    always_ff @(posedge clk) begin
        if (!reset_l) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // One beat issues per enabled cycle: a new command wins over the running burst.
    always_comb begin
        state_nxt = state;
        iss_rd    = 1'b0;
        iss_wr    = 1'b0;
        iss_ba    = b_ba;
        iss_row   = b_row;
        iss_col   = b_col;
        iss_mask  = b_mask;
        iss_ap    = b_ap;
        iss_rem   = b_left - 3'd1;
        if (zs_cke) begin
            if (new_rd || new_wr) begin
                iss_rd   = new_rd;
                iss_wr   = new_wr;
                iss_ba   = zs_ba;
                iss_row  = open_row[zs_ba];
                iss_col  = zs_addr[7:0];
                iss_mask = bl_mask;
                iss_ap   = zs_addr[10];
                iss_rem  = bl_mask;
            end else begin
                iss_rd = (state == S_READ);
                iss_wr = (state == S_WRITE);
            end
            if (iss_rd || iss_wr)
                state_nxt = (iss_rem == 3'd0) ? S_IDLE : (iss_rd ? S_READ : S_WRITE);
        end
    end

    assign col_nxt = (iss_col & ~{5'b0, iss_mask}) | ((iss_col + 8'd1) & {5'b0, iss_mask});
    assign iss_idx = {iss_ba, iss_row, iss_col[COL_KEEP-1:0]};
    assign tap     = cl - 2'd1;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            bank_open <= 4'b0;
            err       <= 3'b0;
            mode_set  <= 1'b0;
            cl        <= 2'd2;
            bl_mask   <= 3'd0;
            b_ba      <= 2'd0;
            b_row     <= '0;
            b_col     <= 8'd0;
            b_mask    <= 3'd0;
            b_left    <= 3'd0;
            b_ap      <= 1'b0;
        end else if (zs_cke) begin
            if (iss_rd || iss_wr) begin
                b_ba   <= iss_ba;
                b_row  <= iss_row;
                b_col  <= col_nxt;
                b_mask <= iss_mask;
                b_left <= iss_rem;
                b_ap   <= iss_ap;
                if (iss_ap && iss_rem == 3'd0) bank_open[iss_ba] <= 1'b0;
            end
            if (is_pre) begin
                if (zs_addr[10]) bank_open <= 4'b0;
                else             bank_open[zs_ba] <= 1'b0;
            end
            if (is_act) begin
                if (bank_open[zs_ba]) err[1] <= 1'b1;
                bank_open[zs_ba] <= 1'b1;
            end
            if ((is_rd || is_wr) && !bank_open[zs_ba]) err[0] <= 1'b1;
            if ((is_rd || is_wr) && !mode_set)         err[2] <= 1'b1;
            if (is_lmr) begin
                mode_set <= 1'b1;
                cl       <= (zs_addr[6:4] == 3'd3) ? 2'd3 : 2'd2;
                case (zs_addr[2:0])
                    3'd1:    bl_mask <= 3'd1;
                    3'd2:    bl_mask <= 3'd3;
                    3'd3:    bl_mask <= 3'd7;
                    default: bl_mask <= 3'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_l && is_act) open_row[zs_ba] <= zs_addr[ROW_KEEP-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset_l && iss_wr) begin
`ifdef SDRAM_DQM_EN
            if (!zs_dqm[0]) mem[iss_idx][7:0]  <= dq_in[7:0];
            if (!zs_dqm[1]) mem[iss_idx][15:8] <= dq_in[15:8];
`else
            mem[iss_idx] <= dq_in;
`endif
        end
    end

    // Index and mask travel with the valid bit; the RAM is read at the CL tap.
    always_ff @(posedge clk) begin
        if (zs_cke) begin
            p_idx[0] <= iss_idx;
            p_idx[1] <= p_idx[0];
            p_idx[2] <= p_idx[1];
            p_dqm[0] <= zs_dqm;
            p_dqm[1] <= p_dqm[0];
            p_dqm[2] <= p_dqm[1];
        end
    end

    always_comb begin
        rd_oe   = p_vld[tap];
        rd_word = p_vld[tap] ? mem[p_idx[tap]] : 16'h0;
`ifdef SDRAM_DQM_EN
        if (p_dqm[tap][0]) rd_word[7:0]  = 8'h0;
        if (p_dqm[tap][1]) rd_word[15:8] = 8'h0;
        if (&p_dqm[tap])   rd_oe = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            p_vld  <= 3'b0;
            dq_out <= 16'h0;
            dq_oe  <= 1'b0;
        end else if (zs_cke) begin
            p_vld  <= {p_vld[1:0], iss_rd};
            dq_out <= rd_word;
            dq_oe  <= rd_oe;
        end
    end
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench for sdram_cmd_responder: command tasks, per-cycle expected read queue, summary line.
module tb_sdram_cmd_responder;
    logic        clk = 1'b0;
    logic        reset_l, zs_cke, zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n;
    logic [1:0]  zs_ba, zs_dqm;
    logic [11:0] zs_addr;
    logic [15:0] dq_in, dq_out;
    logic        dq_oe;
    logic [2:0]  err;

    int          n_checks = 0;
    int          n_bad = 0;
    logic [16:0] exp_q[$];

    sdram_cmd_responder dut (
        .clk(clk), .reset_l(reset_l), .zs_cke(zs_cke), .zs_cs_n(zs_cs_n),
        .zs_ras_n(zs_ras_n), .zs_cas_n(zs_cas_n), .zs_we_n(zs_we_n), .zs_ba(zs_ba),
        .zs_addr(zs_addr), .zs_dqm(zs_dqm), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n} = 4'b0111;
        zs_dqm = 2'b00;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [11:0] addr);
        {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n} = c;
        zs_ba   = ba;
        zs_addr = addr;
    endtask

    task automatic lmr(input logic [2:0] cl, input logic [2:0] bl);
        issue(4'b0000, 2'd0, {5'b0, cl, 1'b0, bl});
        step();
    endtask

    task automatic act(input logic [1:0] ba, input logic [11:0] row);
        issue(4'b0011, ba, row);
        step();
    endtask

    task automatic pre(input logic [1:0] ba, input logic all);
        issue(4'b0010, ba, {1'b0, all, 10'b0});
        step();
    endtask

    task automatic drain(input string tag);
        logic [16:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            check_val({tag, "_oe"}, {31'b0, dq_oe}, {31'b0, e[16]});
            if (e[16]) check_val({tag, "_dq"}, {16'b0, dq_out}, {16'b0, e[15:0]});
        end
    endtask

    initial begin
        reset_l = 1'b0; zs_cke = 1'b1; zs_dqm = 2'b00; dq_in = 16'h0;
        issue(4'b0111, 2'd0, 12'h0);
        step();
        step();
        check_val("rst_dq", {16'b0, dq_out}, 32'h0);
        check_val("rst_oe", {31'b0, dq_oe}, 32'h0);
        check_val("rst_err", {29'b0, err}, 32'h0);
        reset_l = 1'b1;

        // CL=2 BL=1 single word
        lmr(3'd2, 3'd0);
        act(2'd0, 12'd0);
        issue(4'b0100, 2'd0, 12'd0); dq_in = 16'hF055; step();
        issue(4'b0101, 2'd0, 12'd0);
        exp_q.push_back(17'h0); exp_q.push_back(17'h0);
        exp_q.push_back({1'b1, 16'hF055}); exp_q.push_back(17'h0);
        drain("t1");
        check_val("t1_err", {29'b0, err}, 32'h0);

        // CL=3 BL=4 wrapping burst: cols 6,7,4,5 hold 1,2,3,4
        lmr(3'd3, 3'd2);
        issue(4'b0100, 2'd0, 12'd6);
        for (int i = 1; i <= 4; i++) begin
            dq_in = 16'(i);
            step();
        end
        issue(4'b0101, 2'd0, 12'd4);
        for (int i = 0; i < 3; i++) exp_q.push_back(17'h0);
        exp_q.push_back({1'b1, 16'd3}); exp_q.push_back({1'b1, 16'd4});
        exp_q.push_back({1'b1, 16'd1}); exp_q.push_back({1'b1, 16'd2});
        exp_q.push_back(17'h0);
        drain("t2c4");
        issue(4'b0101, 2'd0, 12'd6);
        for (int i = 0; i < 3; i++) exp_q.push_back(17'h0);
        for (int i = 1; i <= 4; i++) exp_q.push_back({1'b1, 16'(i)});
        exp_q.push_back(17'h0);
        drain("t2c6");

        // Closed bank, then double ACTIVE
        issue(4'b0101, 2'd1, 12'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(17'h0);
        drain("t3rd");
        check_val("t3_err0", {29'b0, err}, 32'h1);
        act(2'd0, 12'd5);
        check_val("t3_err1", {29'b0, err}, 32'h3);

        // BL=8 CL=2, burst A truncated by burst B two cycles later
        lmr(3'd2, 3'd3);
        issue(4'b0100, 2'd0, 12'd8);
        for (int i = 0; i < 8; i++) begin
            dq_in = 16'h10 + 16'(i);
            step();
        end
        issue(4'b0101, 2'd0, 12'd8);
        exp_q.push_back(17'h0); exp_q.push_back(17'h0);
        drain("t4a");
        issue(4'b0101, 2'd0, 12'd12);
        exp_q.push_back({1'b1, 16'h10}); exp_q.push_back({1'b1, 16'h11});
        for (int i = 4; i < 8; i++) exp_q.push_back({1'b1, 16'h10 + 16'(i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 16'h10 + 16'(i)});
        exp_q.push_back(17'h0);
        drain("t4b");

        // CKE low for two cycles mid burst
        issue(4'b0101, 2'd0, 12'd8);
        exp_q.push_back(17'h0); exp_q.push_back(17'h0);
        exp_q.push_back({1'b1, 16'h10}); exp_q.push_back({1'b1, 16'h11});
        drain("t5a");
        zs_cke = 1'b0;
        exp_q.push_back({1'b1, 16'h11}); exp_q.push_back({1'b1, 16'h11});
        drain("t5hold");
        zs_cke = 1'b1;
        for (int i = 2; i < 8; i++) exp_q.push_back({1'b1, 16'h10 + 16'(i)});
        exp_q.push_back(17'h0);
        drain("t5b");

        // Reset in the middle of a burst
        issue(4'b0101, 2'd0, 12'd8);
        exp_q.push_back(17'h0); exp_q.push_back(17'h0); exp_q.push_back({1'b1, 16'h10});
        drain("t5c");
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        check_val("t5_rst_oe", {31'b0, dq_oe}, 32'h0);
        check_val("t5_rst_dq", {16'b0, dq_out}, 32'h0);
        check_val("t5_rst_err", {29'b0, err}, 32'h0);

        // Byte-masked write
        lmr(3'd2, 3'd0);
        act(2'd0, 12'd0);
        issue(4'b0100, 2'd0, 12'd3); dq_in = 16'hAAAA; step();
        issue(4'b0100, 2'd0, 12'd3); dq_in = 16'h5555; zs_dqm = 2'b01; step();
        issue(4'b0101, 2'd0, 12'd3);
        exp_q.push_back(17'h0); exp_q.push_back(17'h0);
`ifdef SDRAM_DQM_EN
        exp_q.push_back({1'b1, 16'h55AA});
`else
        exp_q.push_back({1'b1, 16'h5555});
`endif
        drain("t6");

        // Auto-precharge closes the bank; explicit precharge lets ACTIVE reopen cleanly
        act(2'd3, 12'd0);
        issue(4'b0100, 2'd3, 12'd1); dq_in = 16'h1234; step();
        issue(4'b0101, 2'd3, 12'h401);
        exp_q.push_back(17'h0); exp_q.push_back(17'h0); exp_q.push_back({1'b1, 16'h1234});
        drain("t7ap");
        check_val("t7_err_a", {29'b0, err}, 32'h0);
        issue(4'b0101, 2'd3, 12'd1);
        exp_q.push_back(17'h0); exp_q.push_back(17'h0); exp_q.push_back(17'h0);
        drain("t7closed");
        check_val("t7_err_b", {29'b0, err}, 32'h1);
        act(2'd2, 12'd0);
        pre(2'd2, 1'b0);
        act(2'd2, 12'd0);
        check_val("t7_pre", {29'b0, err}, 32'h1);
        pre(2'd0, 1'b1);
        act(2'd0, 12'd0);
        act(2'd2, 12'd0);
        check_val("t7_preall", {29'b0, err}, 32'h1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
